// File: rtl/reg_bank_pkg.sv
// Shared types, default sizes and the round-robin pick helper for reg_bank_arbiter.
package reg_bank_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_DATA_W   = 4;
    localparam int MAX_REQ      = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First valid requester at or above ptr, wrapping modulo num_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 num_req);
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= num_req) idx = idx - num_req;
            if (k < num_req && !pick.found && valid[idx[2:0]]) begin
                pick.found = 1'b1;
                pick.idx   = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Requester/bank bus for reg_bank_arbiter; wp_mask/wr_err exist only with RB_WRITE_PROTECT_EN.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int ID_W   = $clog2(NUM_REQ);

    // Per requester: a write transfers when req_valid[i] & req_ready[i] at a rising edge.
    // Requesters keep addr/data stable while valid; dropping valid before ready withdraws.
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wr_done;
    logic [ID_W-1:0]           wr_id;
    logic [ADDR_W-1:0]         rd_addr;
    logic [DATA_W-1:0]         rd_data;
    state_t                    fsm_state;
`ifdef RB_WRITE_PROTECT_EN
    logic [NUM_REGS-1:0]       wp_mask;
    logic                      wr_err;

    modport master (
        output req_valid, req_addr, req_data, rd_addr, wp_mask,
        input  req_ready, wr_done, wr_id, rd_data, fsm_state, wr_err
    );
    modport slave (
        input  req_valid, req_addr, req_data, rd_addr, wp_mask,
        output req_ready, wr_done, wr_id, rd_data, fsm_state, wr_err
    );
`else
    modport master (
        output req_valid, req_addr, req_data, rd_addr,
        input  req_ready, wr_done, wr_id, rd_data, fsm_state
    );
    modport slave (
        input  req_valid, req_addr, req_data, rd_addr,
        output req_ready, wr_done, wr_id, rd_data, fsm_state
    );
`endif

endinterface

// File: rtl/reg_slot.sv
// One bank slot: rising-edge register with synchronous write enable and async active-low clear.
module reg_slot
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (we) q <= d;
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter and sequencer over a small register bank with a combinational read port.
// Optional per-slot write protect is built when RB_WRITE_PROTECT_EN is defined.
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic      clk,
    input  logic      rst_n,
    reg_bank_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int ID_W   = $clog2(NUM_REQ);

    state_t            state;
    state_t            next_state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [ID_W-1:0]   hold_id;

    rr_pick_t          pick;
    logic [ID_W-1:0]   grant_id;
    logic              handshake;
    logic              slot_we;
    logic              protect;
    logic [DATA_W-1:0] slot_q [NUM_REGS];

    always_comb begin
        pick = rr_pick(MAX_REQ'(bus.req_valid), 3'(rr_ptr), NUM_REQ);
    end

    assign grant_id  = ID_W'(pick.idx);
    assign handshake = (state == IDLE) && pick.found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick.found) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready only ever goes to a valid winner, so a grant is always a completed handshake.
    always_comb begin
        bus.req_ready = '0;
        bus.wr_done   = 1'b0;
        slot_we       = 1'b0;
        if (state == IDLE) begin
            if (pick.found) bus.req_ready[grant_id] = 1'b1;
        end else begin
            bus.wr_done = 1'b1;
            slot_we     = !protect;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_id   <= '0;
        end else if (handshake) begin
            hold_addr <= bus.req_addr[grant_id*ADDR_W +: ADDR_W];
            hold_data <= bus.req_data[grant_id*DATA_W +: DATA_W];
            hold_id   <= grant_id;
            rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

`ifdef RB_WRITE_PROTECT_EN
    assign protect    = bus.wp_mask[hold_addr];
    assign bus.wr_err = (state == COMMIT) && protect;
`else
    assign protect = 1'b0;
`endif

    assign bus.wr_id     = hold_id;
    assign bus.fsm_state = state;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot
        reg_slot #(.DATA_W(DATA_W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (slot_we && (hold_addr == ADDR_W'(g))),
            .d     (hold_data),
            .q     (slot_q[g])
        );
    end

    // The write lands at the edge ending COMMIT, so a same-cycle read still sees the old value.
    assign bus.rd_data = slot_q[bus.rd_addr];

endmodule
